// File: rtl/core_pkg.sv
// Shared types and constants for the RV32I core front end.
package core_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSN = 32'h0000_0013;

  typedef enum logic [1:0] {BOOT, RUN, HALT, FAULT} fetch_state_t;

  // Instruction addresses must be word aligned; only the two LSBs matter.
  function automatic logic is_misaligned(input logic [1:0] addr_lsb);
    return addr_lsb != 2'b00;
  endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Control and status bundle between the decode/execute logic and the fetch stage.
interface pc_fetch_unit_if;
  import core_pkg::*;

  logic            stall;
  logic            branch_taken;
  logic [XLEN-1:0] branch_target;
  logic            jump;
  logic [XLEN-1:0] jump_target;
  logic            halt_req;
  logic            resume;
  logic [XLEN-1:0] resume_pc;

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus4;
  logic            fetch_valid;
  logic            halted;
  logic            fault;
  logic [XLEN-1:0] fault_addr;
  logic            pc_out_of_range;
  logic [XLEN-1:0] retired;

  modport master (
    output stall, branch_taken, branch_target, jump, jump_target,
           halt_req, resume, resume_pc,
    input  pc, pc_plus4, fetch_valid, halted, fault, fault_addr,
           pc_out_of_range, retired
  );

  modport slave (
    input  stall, branch_taken, branch_target, jump, jump_target,
           halt_req, resume, resume_pc,
    output pc, pc_plus4, fetch_valid, halted, fault, fault_addr,
           pc_out_of_range, retired
  );

endinterface

// File: rtl/next_pc_sel.sv
// Next-PC priority mux (halt > jump > branch > pc+4) with redirect alignment check.
module next_pc_sel
  import core_pkg::*;
(
  input  logic [XLEN-1:0] pc,
  input  logic            halt_req,
  input  logic            jump,
  input  logic [XLEN-1:0] jump_target,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  output logic [XLEN-1:0] next_pc,
  output logic            take,
  output logic            misalign
);

  always_comb begin
    next_pc  = pc + XLEN'(4);
    take     = 1'b0;
    misalign = 1'b0;
    if (halt_req) begin
      // The halting instruction retires but the PC stays on it.
      next_pc = pc;
    end else if (jump) begin
      next_pc = jump_target;
      take    = 1'b1;
    end else if (branch_taken) begin
      next_pc = branch_target;
      take    = 1'b1;
    end
    misalign = take && is_misaligned(next_pc[1:0]);
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register, fetch-control FSM and retired-instruction counter for the single-cycle core.
module pc_fetch_unit
  import core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned     MEM_SIZE     = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  pc_fetch_unit_if.slave   bus
);

  fetch_state_t    state_reg, state_next;
  logic [XLEN-1:0] pc_reg, pc_next;
  logic [XLEN-1:0] retired_reg, retired_next;
  logic [XLEN-1:0] fault_addr_reg, fault_addr_next;

  logic [XLEN-1:0] sel_next_pc;
  logic            sel_take;
  logic            sel_misalign;

  next_pc_sel u_next_pc_sel (
    .pc            (pc_reg),
    .halt_req      (bus.halt_req),
    .jump          (bus.jump),
    .jump_target   (bus.jump_target),
    .branch_taken  (bus.branch_taken),
    .branch_target (bus.branch_target),
    .next_pc       (sel_next_pc),
    .take          (sel_take),
    .misalign      (sel_misalign)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= BOOT;
      pc_reg         <= RESET_VECTOR;
      retired_reg    <= '0;
      fault_addr_reg <= '0;
    end else begin
      state_reg      <= state_next;
      pc_reg         <= pc_next;
      retired_reg    <= retired_next;
      fault_addr_reg <= fault_addr_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    pc_next         = pc_reg;
    retired_next    = retired_reg;
    fault_addr_next = fault_addr_reg;
    case (state_reg)
      BOOT: state_next = RUN;
      RUN: begin
        if (!bus.stall) begin
          if (sel_misalign) begin
            state_next      = FAULT;
            fault_addr_next = sel_next_pc;
          end else begin
            pc_next      = sel_next_pc;
            retired_next = retired_reg + XLEN'(1);
            if (bus.halt_req) state_next = HALT;
          end
        end
      end
      HALT, FAULT: begin
        // Only resume is honoured; a bad restart address faults instead of running.
        if (bus.resume) begin
          if (is_misaligned(bus.resume_pc[1:0])) begin
            state_next      = FAULT;
            fault_addr_next = bus.resume_pc;
          end else begin
            state_next = RUN;
            pc_next    = bus.resume_pc;
          end
        end
      end
      default: state_next = BOOT;
    endcase
  end

  assign bus.pc              = pc_reg;
  assign bus.pc_plus4        = pc_reg + XLEN'(4);
  assign bus.fetch_valid     = (state_reg == RUN) && !bus.stall;
  assign bus.halted          = (state_reg == HALT);
  assign bus.fault           = (state_reg == FAULT);
  assign bus.fault_addr      = fault_addr_reg;
  assign bus.retired         = retired_reg;
  assign bus.pc_out_of_range = {2'b00, pc_reg[XLEN-1:2]} >= XLEN'(MEM_SIZE);

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed self-checking bench for pc_fetch_unit with hand-computed expectations.
module tb_pc_fetch_unit;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  pc_fetch_unit_if bus ();

  pc_fetch_unit #(
    .RESET_VECTOR (32'h0000_0000),
    .MEM_SIZE     (128)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_ctl();
    bus.stall         = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.branch_target = 32'h0;
    bus.jump          = 1'b0;
    bus.jump_target   = 32'h0;
    bus.halt_req      = 1'b0;
    bus.resume        = 1'b0;
    bus.resume_pc     = 32'h0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    $display("tx t=%0t pc=%h valid=%b halted=%b fault=%b fault_addr=%h oor=%b retired=%0d",
             $time, bus.pc, bus.fetch_valid, bus.halted, bus.fault, bus.fault_addr,
             bus.pc_out_of_range, bus.retired);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_ctl();
    #3;
    checks++; if (bus.pc !== 32'h0) begin failures++; $display("FAIL reset_pc: got %h expected %h", bus.pc, 32'h0); end
    checks++; if (bus.fetch_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", bus.fetch_valid); end
    checks++; if (bus.halted !== 1'b0 || bus.fault !== 1'b0) begin failures++; $display("FAIL reset_flags: got halted=%b fault=%b expected 0/0", bus.halted, bus.fault); end
    checks++; if (bus.fault_addr !== 32'h0) begin failures++; $display("FAIL reset_fault_addr: got %h expected 0", bus.fault_addr); end
    checks++; if (bus.retired !== 32'h0) begin failures++; $display("FAIL reset_retired: got %0d expected 0", bus.retired); end
  endtask

  task automatic test_boot_sequence();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (bus.pc !== 32'h0 || bus.fetch_valid !== 1'b0) begin failures++; $display("FAIL boot_cycle: got pc=%h valid=%b expected 0/0", bus.pc, bus.fetch_valid); end
    step();
    checks++; if (bus.pc !== 32'h0 || bus.fetch_valid !== 1'b1) begin failures++; $display("FAIL run_first: got pc=%h valid=%b expected 0/1", bus.pc, bus.fetch_valid); end
    step();
    checks++; if (bus.pc !== 32'h4 || bus.retired !== 32'd1) begin failures++; $display("FAIL seq_pc4: got pc=%h retired=%0d expected 4/1", bus.pc, bus.retired); end
    step();
    checks++; if (bus.pc !== 32'h8 || bus.retired !== 32'd2) begin failures++; $display("FAIL seq_pc8: got pc=%h retired=%0d expected 8/2", bus.pc, bus.retired); end
    checks++; if (bus.pc_plus4 !== 32'hC) begin failures++; $display("FAIL seq_plus4: got %h expected c", bus.pc_plus4); end
  endtask

  task automatic test_jump_priority();
    step();
    step();
    checks++; if (bus.pc !== 32'h10 || bus.pc_plus4 !== 32'h14) begin failures++; $display("FAIL pre_jump: got pc=%h plus4=%h expected 10/14", bus.pc, bus.pc_plus4); end
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'h40;
    bus.jump          = 1'b1;
    bus.jump_target   = 32'h80;
    step();
    clear_ctl();
    checks++; if (bus.pc !== 32'h80 || bus.retired !== 32'd5) begin failures++; $display("FAIL jump_over_branch: got pc=%h retired=%0d expected 80/5", bus.pc, bus.retired); end
  endtask

  task automatic test_misaligned_jump();
    bus.jump        = 1'b1;
    bus.jump_target = 32'h20;
    step();
    checks++; if (bus.pc !== 32'h20 || bus.retired !== 32'd6) begin failures++; $display("FAIL jump_20: got pc=%h retired=%0d expected 20/6", bus.pc, bus.retired); end
    bus.jump_target = 32'h22;
    step();
    clear_ctl();
    checks++; if (bus.fault !== 1'b1 || bus.fault_addr !== 32'h22) begin failures++; $display("FAIL fault_entry: got fault=%b addr=%h expected 1/22", bus.fault, bus.fault_addr); end
    checks++; if (bus.pc !== 32'h20 || bus.retired !== 32'd6 || bus.fetch_valid !== 1'b0) begin failures++; $display("FAIL fault_hold: got pc=%h retired=%0d valid=%b expected 20/6/0", bus.pc, bus.retired, bus.fetch_valid); end
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'h40;
    step();
    clear_ctl();
    checks++; if (bus.fault !== 1'b1 || bus.pc !== 32'h20) begin failures++; $display("FAIL fault_ignores_ctl: got fault=%b pc=%h expected 1/20", bus.fault, bus.pc); end
    bus.resume    = 1'b1;
    bus.resume_pc = 32'h0;
    step();
    clear_ctl();
    checks++; if (bus.pc !== 32'h0 || bus.fault !== 1'b0 || bus.fetch_valid !== 1'b1) begin failures++; $display("FAIL fault_resume: got pc=%h fault=%b valid=%b expected 0/0/1", bus.pc, bus.fault, bus.fetch_valid); end
  endtask

  task automatic test_stall_then_halt();
    bus.stall         = 1'b1;
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'h40;
    bus.halt_req      = 1'b1;
    #1;
    checks++; if (bus.fetch_valid !== 1'b0) begin failures++; $display("FAIL stall_valid: got %b expected 0", bus.fetch_valid); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (bus.pc !== 32'h0 || bus.retired !== 32'd6 || bus.halted !== 1'b0 || bus.fault !== 1'b0) begin failures++; $display("FAIL stall_hold_%0d: got pc=%h retired=%0d halted=%b fault=%b expected 0/6/0/0", i, bus.pc, bus.retired, bus.halted, bus.fault); end
    end
    clear_ctl();
    bus.halt_req = 1'b1;
    step();
    clear_ctl();
    checks++; if (bus.halted !== 1'b1 || bus.retired !== 32'd7 || bus.pc !== 32'h0) begin failures++; $display("FAIL halt_entry: got halted=%b retired=%0d pc=%h expected 1/7/0", bus.halted, bus.retired, bus.pc); end
    bus.jump        = 1'b1;
    bus.jump_target = 32'h40;
    step();
    clear_ctl();
    checks++; if (bus.halted !== 1'b1 || bus.pc !== 32'h0 || bus.fetch_valid !== 1'b0) begin failures++; $display("FAIL halt_ignores_jump: got halted=%b pc=%h valid=%b expected 1/0/0", bus.halted, bus.pc, bus.fetch_valid); end
  endtask

  task automatic test_resume_misaligned();
    bus.resume    = 1'b1;
    bus.resume_pc = 32'h6;
    step();
    clear_ctl();
    checks++; if (bus.fault !== 1'b1 || bus.halted !== 1'b0 || bus.fault_addr !== 32'h6 || bus.pc !== 32'h0) begin failures++; $display("FAIL resume_misaligned: got fault=%b halted=%b addr=%h pc=%h expected 1/0/6/0", bus.fault, bus.halted, bus.fault_addr, bus.pc); end
    bus.resume    = 1'b1;
    bus.resume_pc = 32'h1F8;
    step();
    clear_ctl();
    checks++; if (bus.pc !== 32'h1F8 || bus.fault !== 1'b0 || bus.retired !== 32'd7) begin failures++; $display("FAIL resume_1f8: got pc=%h fault=%b retired=%0d expected 1f8/0/7", bus.pc, bus.fault, bus.retired); end
  endtask

  task automatic test_out_of_range();
    step();
    checks++; if (bus.pc !== 32'h1FC || bus.pc_out_of_range !== 1'b0) begin failures++; $display("FAIL oor_last_word: got pc=%h flag=%b expected 1fc/0", bus.pc, bus.pc_out_of_range); end
    step();
    checks++; if (bus.pc !== 32'h200 || bus.pc_out_of_range !== 1'b1 || bus.fetch_valid !== 1'b1) begin failures++; $display("FAIL oor_past_end: got pc=%h flag=%b valid=%b expected 200/1/1", bus.pc, bus.pc_out_of_range, bus.fetch_valid); end
    checks++; if (bus.retired !== 32'd9) begin failures++; $display("FAIL oor_retired: got %0d expected 9", bus.retired); end
  endtask

  task automatic test_pc_wrap();
    bus.jump        = 1'b1;
    bus.jump_target = 32'hFFFF_FFFC;
    step();
    clear_ctl();
    checks++; if (bus.pc !== 32'hFFFF_FFFC || bus.pc_plus4 !== 32'h0) begin failures++; $display("FAIL wrap_top: got pc=%h plus4=%h expected fffffffc/0", bus.pc, bus.pc_plus4); end
    step();
    checks++; if (bus.pc !== 32'h0 || bus.retired !== 32'd11 || bus.fault !== 1'b0) begin failures++; $display("FAIL wrap_zero: got pc=%h retired=%0d fault=%b expected 0/11/0", bus.pc, bus.retired, bus.fault); end
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'h31;
    step();
    clear_ctl();
    checks++; if (bus.fault !== 1'b1 || bus.fault_addr !== 32'h31 || bus.retired !== 32'd11) begin failures++; $display("FAIL branch_misaligned: got fault=%b addr=%h retired=%0d expected 1/31/11", bus.fault, bus.fault_addr, bus.retired); end
    bus.resume    = 1'b1;
    bus.resume_pc = 32'h100;
    step();
    clear_ctl();
    bus.halt_req = 1'b1;
    step();
    clear_ctl();
    checks++; if (bus.halted !== 1'b1 || bus.pc !== 32'h100 || bus.retired !== 32'd12) begin failures++; $display("FAIL halt_at_100: got halted=%b pc=%h retired=%0d expected 1/100/12", bus.halted, bus.pc, bus.retired); end
  endtask

  task automatic test_async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.halted !== 1'b0 || bus.pc !== 32'h0 || bus.retired !== 32'h0 || bus.fault_addr !== 32'h0) begin failures++; $display("FAIL async_reset: got halted=%b pc=%h retired=%0d addr=%h expected 0/0/0/0", bus.halted, bus.pc, bus.retired, bus.fault_addr); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (bus.pc !== 32'h0 || bus.fetch_valid !== 1'b0) begin failures++; $display("FAIL reboot_cycle: got pc=%h valid=%b expected 0/0", bus.pc, bus.fetch_valid); end
    step();
    checks++; if (bus.pc !== 32'h0 || bus.fetch_valid !== 1'b1) begin failures++; $display("FAIL reboot_run: got pc=%h valid=%b expected 0/1", bus.pc, bus.fetch_valid); end
    step();
    checks++; if (bus.pc !== 32'h4 || bus.retired !== 32'd1) begin failures++; $display("FAIL reboot_seq: got pc=%h retired=%0d expected 4/1", bus.pc, bus.retired); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_boot_sequence();
    test_jump_priority();
    test_misaligned_jump();
    test_stall_then_halt();
    test_resume_misaligned();
    test_out_of_range();
    test_pc_wrap();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
